// File: rtl/poly_small_mkgauss_mc_pkg.sv
// Shared types and constants for the multi-channel small-polynomial Gaussian sampler.
// Holds the controller state encoding and the coefficient range check.
package poly_small_pkg;

  localparam int MAX_LOGN = 10;
  localparam int RNG_W    = 128;
  localparam int SAMPLE_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Symmetric window: the most negative CW-bit code is excluded so negation stays representable.
  function automatic logic in_bound(input logic signed [SAMPLE_W-1:0] val, input int cw);
    logic signed [SAMPLE_W-1:0] lim;
    lim = $signed((32'd1 << (cw - 1)) - 32'd1);
    return (val >= -lim) && (val <= lim);
  endfunction

endpackage

// File: rtl/poly_small_mkgauss_mc_if.sv
// Coefficient output stream: valid/ready handshake with index, channel and last-of-polynomial tag.
interface poly_small_mkgauss_mc_if #(
  parameter int LOGN = 9,
  parameter int CW   = 8
);
  logic                   coef_valid;
  logic                   coef_ready;
  logic signed [CW-1:0]   coef;
  logic [LOGN-1:0]        coef_idx;
  logic [1:0]             coef_ch;
  logic                   coef_last;

  modport master (
    output coef_valid, coef, coef_idx, coef_ch, coef_last,
    input  coef_ready
  );

  modport slave (
    input  coef_valid, coef, coef_idx, coef_ch, coef_last,
    output coef_ready
  );
endinterface

// File: rtl/poly_small_mkgauss_mc_mkgauss.sv
// Gaussian sampler core: one random word per extract, sample ready one cycle later.
// The sample is a 32-bit offset from the top word plus a centered binomial spread over the low 96 bits.
module mkgauss
  import poly_small_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       rng_valid,
  input  logic [RNG_W-1:0]           rng,
  output logic                       rng_extract,
  output logic signed [SAMPLE_W-1:0] val,
  output logic                       val_valid
);

  logic signed [SAMPLE_W-1:0] spread;

  assign rng_extract = ena && rng_valid;

  // Centered binomial: ones in the low 48 bits minus ones in the next 48 bits.
  always_comb begin
    spread = '0;
    for (int k = 0; k < 48; k++) begin
      spread = spread + $signed(SAMPLE_W'(rng[k])) - $signed(SAMPLE_W'(rng[k + 48]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_valid <= 1'b0;
      val       <= '0;
    end else begin
      val_valid <= rng_extract;
      if (rng_extract) begin
        val <= $signed(rng[RNG_W-1 -: SAMPLE_W]) + spread;
      end
    end
  end

endmodule

// File: rtl/poly_small_mkgauss_mc.sv
// Multi-channel small-coefficient polynomial generator: filters sampler output by range
// and odd per-channel parity, and streams coefficients through a 2-entry FIFO.
module poly_small_mkgauss_mc
  import poly_small_pkg::*;
#(
  parameter int LOGN = 9,
  parameter int CW   = 8,
  parameter int NCH  = 2
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   par_en,
  input  logic                   rng_valid,
  input  logic [RNG_W-1:0]       rng,
  output logic                   rng_extract,
  poly_small_mkgauss_mc_if.master coef_bus,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            rej_cnt,
  output logic                   ovf
);

  localparam int IDX_W = (LOGN > MAX_LOGN) ? MAX_LOGN : LOGN;
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
  localparam logic [1:0]       CH_LAST  = 2'(NCH - 1);

  typedef struct packed {
    logic signed [CW-1:0] coef;
    logic [IDX_W-1:0]     idx;
    logic [1:0]           ch;
  } entry_t;

  state_t                     state;
  entry_t                     mem [2];
  entry_t                     head;
  logic                       rd_ptr, wr_ptr;
  logic [1:0]                 count;
  logic [IDX_W-1:0]           idx;
  logic [1:0]                 ch;
  logic                       parity;
  logic                       par_en_q;

  logic                       sampler_ena;
  logic signed [SAMPLE_W-1:0] val;
  logic                       val_valid;

  logic pop, space, vv_run, at_last, par_ok, in_rng;
  logic accept, reject_range, drop_ovf, final_acc, head_final;

  mkgauss u_mkgauss (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (sampler_ena),
    .rng_valid   (rng_valid),
    .rng         (rng),
    .rng_extract (rng_extract),
    .val         (val),
    .val_valid   (val_valid)
  );

  // Only request a new sample once the FIFO is fully drained; with the sampler's one-cycle
  // latency this bounds in-flight samples to two, which the FIFO can always absorb.
  assign sampler_ena = (state == RUN) && (count == 2'd0);
  assign busy        = (state != IDLE);

  assign head                = mem[rd_ptr];
  assign coef_bus.coef_valid = (count != 2'd0);
  assign coef_bus.coef       = coef_bus.coef_valid ? head.coef : '0;
  assign coef_bus.coef_idx   = coef_bus.coef_valid ? head.idx  : '0;
  assign coef_bus.coef_ch    = coef_bus.coef_valid ? head.ch   : '0;
  assign coef_bus.coef_last  = coef_bus.coef_valid && (head.idx == IDX_LAST);

  always_comb begin
    pop          = coef_bus.coef_valid && coef_bus.coef_ready;
    space        = (count != 2'd2) || pop;
    vv_run       = val_valid && (state == RUN);
    in_rng       = in_bound(val, CW);
    at_last      = (idx == IDX_LAST);
    par_ok       = !(par_en_q && at_last) || (parity ^ val[0]);
    accept       = vv_run && space && in_rng && par_ok;
    reject_range = vv_run && space && !in_rng;
    drop_ovf     = vv_run && !space;
    final_acc    = accept && at_last && (ch == CH_LAST);
    head_final   = (head.idx == IDX_LAST) && (head.ch == CH_LAST);
  end

  // Controller, FIFO and statistics share one register block so abort can flush them together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      idx      <= '0;
      ch       <= '0;
      parity   <= 1'b0;
      par_en_q <= 1'b0;
      rej_cnt  <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        mem[k] <= '0;
      end
    end else if (abort) begin
      state  <= IDLE;
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= pop && head_final;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            idx      <= '0;
            ch       <= '0;
            parity   <= 1'b0;
            par_en_q <= par_en;
            rej_cnt  <= '0;
            ovf      <= 1'b0;
          end
        end
        RUN: begin
          if (final_acc) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        mem[wr_ptr] <= '{coef: val[CW-1:0], idx: idx, ch: ch};
        wr_ptr      <= ~wr_ptr;
        idx         <= idx + 1'b1;
        if (at_last) begin
          ch     <= ch + 2'd1;
          parity <= 1'b0;
        end else begin
          parity <= parity ^ val[0];
        end
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, accept} - {1'b0, pop};

      if (reject_range && (rej_cnt != 16'hFFFF)) begin
        rej_cnt <= rej_cnt + 16'd1;
      end
      if (drop_ovf) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_poly_small_mkgauss_mc.sv
// Directed and randomised checks of the coefficient generator against a queue-based model
// of the accept/reject rules (LOGN=2, CW=8, NCH=2).
module tb_poly_small_mkgauss_mc;

  localparam int LOGN = 2;
  localparam int CW   = 8;
  localparam int NCH  = 2;
  localparam int N    = 1 << LOGN;
  localparam int LIM  = (1 << (CW - 1)) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         par_en = 1'b0;
  logic         rng_valid = 1'b0;
  logic [127:0] rng = '0;
  logic         rng_extract, busy, done, ovf;
  logic [15:0]  rej_cnt;

  poly_small_mkgauss_mc_if #(.LOGN(LOGN), .CW(CW)) bus ();

  poly_small_mkgauss_mc #(.LOGN(LOGN), .CW(CW), .NCH(NCH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .par_en      (par_en),
    .rng_valid   (rng_valid),
    .rng         (rng),
    .rng_extract (rng_extract),
    .coef_bus    (bus),
    .busy        (busy),
    .done        (done),
    .rej_cnt     (rej_cnt),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] coef;
    int         idx;
    int         ch;
    bit         last;
    bit         fin;
  } exp_t;

  int           n_vec = 0;
  int           n_bad = 0;
  exp_t         exp_q[$];
  logic [127:0] feed_q[$];
  logic [7:0]   got_q[$];
  int           m_idx, m_ch, m_rej;
  bit           m_par, m_par_en, m_active;
  int           done_cnt = 0;
  int           pop_cnt = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic int sample_of(input logic [127:0] r);
    return $signed(r[127:96]) + $countones(r[47:0]) - $countones(r[95:48]);
  endfunction

  // Reference behaviour: range filter, odd parity per channel, in-order (ch, idx) tagging.
  task automatic model_consume(input logic [127:0] r);
    int         v;
    logic [31:0] vv;
    exp_t       e;
    if (!m_active) return;
    v  = sample_of(r);
    vv = v;
    if (v < -LIM || v > LIM) begin
      if (m_rej < 65535) m_rej++;
      return;
    end
    if (m_par_en && m_idx == N - 1 && (m_par ^ vv[0]) == 1'b0) return;
    e.coef = vv[7:0];
    e.idx  = m_idx;
    e.ch   = m_ch;
    e.last = (m_idx == N - 1);
    e.fin  = (m_idx == N - 1) && (m_ch == NCH - 1);
    exp_q.push_back(e);
    if (m_idx == N - 1) begin
      m_idx = 0;
      m_par = 1'b0;
      m_ch++;
      if (m_ch == NCH) m_active = 1'b0;
    end else begin
      m_par ^= vv[0];
      m_idx++;
    end
  endtask

  task automatic model_flush();
    m_active = 1'b0;
    exp_q.delete();
    feed_q.delete();
  endtask

  task automatic push_val(input int v, input logic [95:0] lo);
    feed_q.push_back({32'(v), lo});
  endtask

  task automatic apply_stimulus(input bit pe);
    @(negedge clk);
    m_idx = 0; m_ch = 0; m_rej = 0; m_par = 1'b0; m_par_en = pe; m_active = 1'b1;
    exp_q.delete();
    got_q.delete();
    par_en = pe;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int  d0;
    bit  seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      #4;
      seen = (done_cnt > d0);
    end
    check_output({name, " done"}, 32'(seen), 32'd1);
    check_output({name, " leftover"}, 32'(exp_q.size()), 32'd0);
    check_output({name, " busy after"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int  p0;
    bit  ok;
    p0 = pop_cnt;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      #4;
      ok = (pop_cnt - p0 >= target);
    end
    check_output({name, " pops reached"}, 32'(ok), 32'd1);
  endtask

  task automatic reset_checks(input string tag);
    check_output({tag, " coef_valid"}, 32'(bus.coef_valid), 32'd0);
    check_output({tag, " coef"}, 32'(bus.coef), 32'd0);
    check_output({tag, " coef_idx"}, 32'(bus.coef_idx), 32'd0);
    check_output({tag, " coef_ch"}, 32'(bus.coef_ch), 32'd0);
    check_output({tag, " coef_last"}, 32'(bus.coef_last), 32'd0);
    check_output({tag, " busy"}, 32'(busy), 32'd0);
    check_output({tag, " done"}, 32'(done), 32'd0);
    check_output({tag, " rej_cnt"}, 32'(rej_cnt), 32'd0);
    check_output({tag, " ovf"}, 32'(ovf), 32'd0);
    check_output({tag, " rng_extract"}, 32'(rng_extract), 32'd0);
  endtask

  // Feeder: presents queued random words and hands each consumed word to the model.
  initial begin
    bit pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (pend && feed_q.size() > 0) begin
        model_consume(feed_q[0]);
        void'(feed_q.pop_front());
      end
      if (feed_q.size() > 0) begin
        rng       = feed_q[0];
        rng_valid = 1'b1;
      end else begin
        rng       = '0;
        rng_valid = 1'b0;
      end
      #1;
      pend = rng_extract && rst_n;
    end
  end

  // Compare process: every handshake against the model queue, hold stability, done timing.
  initial begin
    bit         pend_done, held;
    exp_t       e;
    logic [7:0] c, hc;
    logic [1:0] hch;
    logic [LOGN-1:0] hidx;
    pend_done = 1'b0;
    held      = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      check_output("done pulse", 32'(done), 32'(pend_done));
      pend_done = 1'b0;
      c = bus.coef;
      if (bus.coef_valid && bus.coef_ready) begin
        pop_cnt++;
        got_q.push_back(c);
        held = 1'b0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("[TB] FAIL unexpected coef: got 0x%0h ch %0d idx %0d, expected none", c, bus.coef_ch, bus.coef_idx);
        end else begin
          e = exp_q.pop_front();
          check_output("coef", 32'(c), 32'(e.coef));
          check_output("coef_idx", 32'(bus.coef_idx), 32'(e.idx));
          check_output("coef_ch", 32'(bus.coef_ch), 32'(e.ch));
          check_output("coef_last", 32'(bus.coef_last), 32'(e.last));
          if (e.fin) pend_done = 1'b1;
        end
      end else if (bus.coef_valid) begin
        if (held) begin
          check_output("hold coef", 32'(c), 32'(hc));
          check_output("hold idx", 32'(bus.coef_idx), 32'(hidx));
          check_output("hold ch", 32'(bus.coef_ch), 32'(hch));
        end
        held = 1'b1;
        hc   = c;
        hidx = bus.coef_idx;
        hch  = bus.coef_ch;
      end else begin
        held = 1'b0;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] par_lit [8];
    logic [7:0] rng_lit [8];
    int         d0;
    bit         pbit;

    par_lit = '{8'h03, 8'hFF, 8'h04, 8'h01, 8'h05, 8'h07, 8'hFE, 8'h01};
    rng_lit = '{8'h81, 8'h7F, 8'h0A, 8'h14, 8'h1E, 8'h28, 8'h32, 8'h3C};
    bus.coef_ready = 1'b1;

    repeat (3) @(negedge clk);
    #4;
    reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Parity: ch0 3,-1,4 leaves parity 0, so 2 is refused and 1 closes the channel.
    $display("[TB] parity run");
    foreach (par_lit[i]) begin end
    push_val(3, '0); push_val(-1, '0); push_val(4, '0); push_val(2, '0); push_val(1, '0);
    push_val(5, '0); push_val(7, '0); push_val(-2, '0); push_val(6, '0); push_val(1, '0);
    apply_stimulus(1'b1);
    wait_done("parity", 200);
    check_output("parity count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check_output("parity lit", 32'(got_q[i]), 32'(par_lit[i]));
    check_output("parity rej_cnt", 32'(rej_cnt), 32'd0);
    check_output("parity model rej", 32'(m_rej), 32'd0);

    // Range: 200, -128 and 300 fall outside +-127.
    $display("[TB] range run");
    push_val(200, '0); push_val(-127, '0); push_val(127, '0); push_val(-128, '0);
    push_val(300, '0); push_val(10, '0); push_val(20, '0);
    push_val(30, '0); push_val(40, '0); push_val(50, '0); push_val(60, '0);
    apply_stimulus(1'b0);
    wait_done("range", 200);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check_output("range lit", 32'(got_q[i]), 32'(rng_lit[i]));
    check_output("range rej_cnt", 32'(rej_cnt), 32'd3);
    check_output("range model rej", 32'(m_rej), 32'd3);

    // Backpressure: FIFO fills, sampler is starved, nothing is lost.
    $display("[TB] backpressure run");
    bus.coef_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push_val(i, '0);
    apply_stimulus(1'b0);
    repeat (20) @(negedge clk);
    #4;
    check_output("bp rng_extract", 32'(rng_extract), 32'd0);
    check_output("bp rng_valid", 32'(rng_valid), 32'd1);
    check_output("bp coef_valid", 32'(bus.coef_valid), 32'd1);
    check_output("bp ovf", 32'(ovf), 32'd0);
    check_output("bp busy", 32'(busy), 32'd1);
    @(negedge clk);
    bus.coef_ready = 1'b1;
    wait_done("bp", 200);
    check_output("bp count", 32'(got_q.size()), 32'd8);
    check_output("bp ovf end", 32'(ovf), 32'd0);

    // Abort part-way through; then a clean run.
    $display("[TB] abort run");
    for (int i = 1; i <= 12; i++) push_val(i, '0);
    apply_stimulus(1'b0);
    wait_pops("abort", 5, 200);
    d0 = done_cnt;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #4;
    check_output("abort busy", 32'(busy), 32'd0);
    check_output("abort coef_valid", 32'(bus.coef_valid), 32'd0);
    model_flush();
    repeat (5) @(negedge clk);
    #4;
    check_output("abort no done", 32'(done_cnt), 32'(d0));
    for (int i = 21; i <= 28; i++) push_val(i, '0);
    apply_stimulus(1'b0);
    wait_done("post abort", 200);
    check_output("post abort count", 32'(got_q.size()), 32'd8);

    // Reset mid-run; then a full run from ch0 idx0.
    $display("[TB] reset run");
    for (int i = 1; i <= 12; i++) push_val(-i, '0);
    apply_stimulus(1'b0);
    wait_pops("reset", 3, 200);
    @(negedge clk);
    rst_n = 1'b0;
    #4;
    reset_checks("mid reset");
    model_flush();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 31; i <= 38; i++) push_val(i, '0);
    apply_stimulus(1'b0);
    wait_done("post reset", 200);
    check_output("post reset first", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'd31);

    // Random with parity, then without.
    $display("[TB] random runs");
    for (int i = 0; i < 80; i++) push_val(int'($urandom_range(260, 0)) - 130, {$urandom, $urandom, $urandom});
    apply_stimulus(1'b1);
    wait_done("rand par", 600);
    for (int c = 0; c < NCH; c++) begin
      pbit = 1'b0;
      for (int i = 0; i < N; i++) if (c * N + i < got_q.size()) pbit ^= got_q[c * N + i][0];
      check_output("rand odd parity", 32'(pbit), 32'd1);
    end
    check_output("rand par rej_cnt", 32'(rej_cnt), 32'(m_rej));
    feed_q.delete();
    for (int i = 0; i < 80; i++) push_val(int'($urandom_range(260, 0)) - 130, {$urandom, $urandom, $urandom});
    apply_stimulus(1'b0);
    wait_done("rand nopar", 600);
    check_output("rand nopar rej_cnt", 32'(rej_cnt), 32'(m_rej));
    check_output("rand ovf", 32'(ovf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
